// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Multicycle MIPS control FSM. Sequences each instruction over several
//   clocks around a shared ALU and a single memory port with a req/ready
//   handshake and a bounded wait (timeout raises sticky bus_err).
//
//   Optional feature macro: EXCEPTION_EN
//     defined   : unknown opcode or memory timeout enters TRAP (PC -> r31,
//                 PC <- vector supplied on the jump-target input).
//     undefined : unknown opcode acts as NOP, timeout returns to FETCH.
//
//   Opcodes: R 000000, J 000010, BEQ 000100, ADDI 001000, ANDI 001100,
//            LW 100011, SW 101011, PUSH 111100, BGT 111101, NOP 111110.
//   R-type funct -> alucontrol: add 100000, sub 100010, and 100100,
//            or 100101, slt 101010, slte 101011, mflo 010010, mtlo 010011,
//            JALR 001001 (own state).
//
//   Ports
//     clk, reset_n        clock, synchronous active-low reset
//     op, funct           instruction fields from IR
//     zero                ALU zero flag
//     mem_ready           memory completes the current access
//     mem_req, memwrite   memory request / write qualifier
//     iord, irwrite, pcen, regwrite, regdst, memtoreg,
//     alusrca, alusrcb, pcsrc, alucontrol   datapath strobes
//     bus_err             sticky memory timeout flag
//     state_dbg           current state encoding
module multicycle_controller #(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic       regwrite,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       bus_err,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR  = 4'd2,  MEMRD   = 4'd3,
        MEMWB   = 4'd4,  MEMWR   = 4'd5,  EXEC_R  = 4'd6,  ALUWB   = 4'd7,
        EXEC_I  = 4'd8,  IWB     = 4'd9,  BRANCH  = 4'd10, JUMP    = 4'd11,
        PUSH_WR = 4'd12, PUSH_WB = 4'd13, JALR_S  = 4'd14, TRAP    = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_PUSH  = 6'b111100;
    localparam logic [5:0] OP_BGT   = 6'b111101;
    localparam logic [5:0] OP_NOP   = 6'b111110;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    // Last counter value a memory state may see before timing out.
    localparam logic [CNT_W-1:0] LAST_WAIT =
        CNT_W'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);

`ifdef EXCEPTION_EN
    localparam state_t BAD_OP_DEST  = TRAP;
    localparam state_t TIMEOUT_DEST = TRAP;
`else
    localparam state_t BAD_OP_DEST  = FETCH;
    localparam state_t TIMEOUT_DEST = FETCH;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
    logic             is_mem, timeout;
    logic             pcwrite, branch;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= FETCH;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign is_mem  = (state_q == FETCH) || (state_q == MEMRD) ||
                     (state_q == MEMWR) || (state_q == PUSH_WR);
    assign timeout = (WAIT_LIMIT != 0) && is_mem && !mem_ready &&
                     (cnt_q == LAST_WAIT);

    // Next-state logic. The counter defaults to zero so every entry into a
    // memory state (including FETCH re-entered after a timeout) starts fresh.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        bus_err_d = bus_err_q;
        unique case (state_q)
            FETCH:   if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW:      state_d = MEMADR;
                    OP_RTYPE:          state_d = (funct == FN_JALR) ? JALR_S : EXEC_R;
                    OP_ADDI, OP_ANDI:  state_d = EXEC_I;
                    OP_BEQ, OP_BGT:    state_d = BRANCH;
                    OP_J:              state_d = JUMP;
                    OP_PUSH:           state_d = PUSH_WR;
                    OP_NOP:            state_d = FETCH;
                    default:           state_d = BAD_OP_DEST;
                endcase
            end
            MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (mem_ready) state_d = MEMWB;
            MEMWR:   if (mem_ready) state_d = FETCH;
            EXEC_R:  state_d = ALUWB;
            EXEC_I:  state_d = IWB;
            PUSH_WR: if (mem_ready) state_d = PUSH_WB;
            default: state_d = FETCH;
        endcase
        if (timeout) begin
            state_d   = TIMEOUT_DEST;
            bus_err_d = 1'b1;
        end else if (is_mem && !mem_ready && (WAIT_LIMIT != 0)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Output decode
    always_comb begin
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        regwrite   = 1'b0;
        regdst     = 2'b00;
        memtoreg   = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b010;
        unique case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            DECODE:  alusrcb = 2'b11;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 2'b01;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            EXEC_R: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    6'b010010: alucontrol = 3'b011;
                    6'b010011: alucontrol = 3'b100;
                    6'b101011: alucontrol = 3'b101;
                    default:   alucontrol = 3'b010;
                endcase
            end
            ALUWB: begin
                regwrite = 1'b1;
                regdst   = 2'b01;
            end
            EXEC_I: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = (op == OP_ANDI) ? 3'b000 : 3'b010;
            end
            IWB:     regwrite = 1'b1;
            BRANCH: begin
                alusrca    = 1'b1;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                alucontrol = (op == OP_BGT) ? 3'b111 : 3'b110;
            end
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            PUSH_WR: begin
                alusrca  = 1'b1;
                alusrcb  = 2'b11;
                mem_req  = 1'b1;
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            PUSH_WB: begin
                regwrite = 1'b1;
                regdst   = 2'b11;
            end
            JALR_S: begin
                regwrite = 1'b1;
                regdst   = 2'b10;
                memtoreg = 2'b10;
                pcsrc    = 2'b11;
                pcwrite  = 1'b1;
            end
            TRAP: begin
                regwrite = 1'b1;
                regdst   = 2'b10;
                memtoreg = 2'b10;
                pcsrc    = 2'b10;
                pcwrite  = 1'b1;
            end
            default: ;
        endcase
        pcen = pcwrite | (branch & zero);
    end

    assign bus_err   = bus_err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a per-cycle vector table for the
// main instruction flows, then hand-written sequences for timeout, reset
// mid-instruction, ready-on-last-wait-cycle and unknown opcode.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       mem_req, memwrite, iord, irwrite, pcen, regwrite;
    logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
    logic       alusrca, bus_err;
    logic [2:0] alucontrol;
    logic [3:0] state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_controller #(.WAIT_LIMIT(15), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite),
        .iord(iord), .irwrite(irwrite), .pcen(pcen), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .bus_err(bus_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // {mem_req,memwrite,iord,irwrite,pcen,regwrite,regdst,memtoreg,
    //  alusrca,alusrcb,pcsrc,alucontrol,bus_err}
    logic [18:0] outs;
    assign outs = {mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst,
                   memtoreg, alusrca, alusrcb, pcsrc, alucontrol, bus_err};

    localparam logic [18:0] O_FETCH_R = 19'b1_0_0_1_1_0_00_00_0_01_00_010_0;
    localparam logic [18:0] O_FETCH_W = 19'b1_0_0_0_0_0_00_00_0_01_00_010_0;
    localparam logic [18:0] O_DECODE  = 19'b0_0_0_0_0_0_00_00_0_11_00_010_0;
    localparam logic [18:0] O_MEMADR  = 19'b0_0_0_0_0_0_00_00_1_10_00_010_0;
    localparam logic [18:0] O_MEMRD   = 19'b1_0_1_0_0_0_00_00_0_00_00_010_0;
    localparam logic [18:0] O_MEMWB   = 19'b0_0_0_0_0_1_00_01_0_00_00_010_0;
    localparam logic [18:0] O_BEQ_T   = 19'b0_0_0_0_1_0_00_00_1_00_01_110_0;
    localparam logic [18:0] O_BEQ_NT  = 19'b0_0_0_0_0_0_00_00_1_00_01_110_0;
    localparam logic [18:0] O_JALR    = 19'b0_0_0_0_1_1_10_10_0_00_11_010_0;
    localparam logic [18:0] O_SLT     = 19'b0_0_0_0_0_0_00_00_1_00_00_111_0;
    localparam logic [18:0] O_ALUWB   = 19'b0_0_0_0_0_1_01_00_0_00_00_010_0;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_NOP = 6'b111110;
    localparam logic [5:0] OP_BAD = 6'b010101;
    localparam logic [5:0] FN_JALR = 6'b001001;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [18:0] outs;
    } vec_t;

    vec_t tbl [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        // LW: 0,1,2,3,4
        tbl[0]  = '{OP_LW,  6'd0,    1'b0, 1'b1, 4'd0,  O_FETCH_R};
        tbl[1]  = '{OP_LW,  6'd0,    1'b0, 1'b1, 4'd1,  O_DECODE};
        tbl[2]  = '{OP_LW,  6'd0,    1'b0, 1'b1, 4'd2,  O_MEMADR};
        tbl[3]  = '{OP_LW,  6'd0,    1'b0, 1'b1, 4'd3,  O_MEMRD};
        tbl[4]  = '{OP_LW,  6'd0,    1'b0, 1'b1, 4'd4,  O_MEMWB};
        // BEQ taken
        tbl[5]  = '{OP_BEQ, 6'd0,    1'b1, 1'b1, 4'd0,  O_FETCH_R};
        tbl[6]  = '{OP_BEQ, 6'd0,    1'b1, 1'b1, 4'd1,  O_DECODE};
        tbl[7]  = '{OP_BEQ, 6'd0,    1'b1, 1'b1, 4'd10, O_BEQ_T};
        // BEQ not taken
        tbl[8]  = '{OP_BEQ, 6'd0,    1'b0, 1'b1, 4'd0,  O_FETCH_R};
        tbl[9]  = '{OP_BEQ, 6'd0,    1'b0, 1'b1, 4'd1,  O_DECODE};
        tbl[10] = '{OP_BEQ, 6'd0,    1'b0, 1'b1, 4'd10, O_BEQ_NT};
        // JALR
        tbl[11] = '{OP_R,   FN_JALR, 1'b0, 1'b1, 4'd0,  O_FETCH_R};
        tbl[12] = '{OP_R,   FN_JALR, 1'b0, 1'b1, 4'd1,  O_DECODE};
        tbl[13] = '{OP_R,   FN_JALR, 1'b0, 1'b1, 4'd14, O_JALR};
        // SLT
        tbl[14] = '{OP_R,   FN_SLT,  1'b0, 1'b1, 4'd0,  O_FETCH_R};
        tbl[15] = '{OP_R,   FN_SLT,  1'b0, 1'b1, 4'd1,  O_DECODE};
        tbl[16] = '{OP_R,   FN_SLT,  1'b0, 1'b1, 4'd6,  O_SLT};
        tbl[17] = '{OP_R,   FN_SLT,  1'b0, 1'b1, 4'd7,  O_ALUWB};
        // SLT with one fetch wait cycle
        tbl[18] = '{OP_R,   FN_SLT,  1'b0, 1'b0, 4'd0,  O_FETCH_W};
        tbl[19] = '{OP_R,   FN_SLT,  1'b0, 1'b1, 4'd0,  O_FETCH_R};
        tbl[20] = '{OP_R,   FN_SLT,  1'b0, 1'b1, 4'd1,  O_DECODE};
        tbl[21] = '{OP_R,   FN_SLT,  1'b0, 1'b1, 4'd6,  O_SLT};
        tbl[22] = '{OP_R,   FN_SLT,  1'b0, 1'b1, 4'd7,  O_ALUWB};

        reset_n = 1'b0; op = OP_NOP; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            op = tbl[i].op; funct = tbl[i].funct; zero = tbl[i].zero; mem_ready = tbl[i].rdy;
            #1;
            chk($sformatf("vec%0d_state", i), 32'(state_dbg), 32'(tbl[i].st));
            chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(tbl[i].outs));
            @(negedge clk);
        end

        // SW with memory never ready: 15 wait cycles then timeout.
        begin
            int n;
            op = OP_SW; funct = '0; zero = 1'b0; mem_ready = 1'b1;
            #1 chk("sw_fetch_state", 32'(state_dbg), 32'd0);
            @(negedge clk);
            @(negedge clk);
            mem_ready = 1'b0;
            @(negedge clk);
            n = 0;
            for (int k = 0; k < 20; k++) begin
                #1;
                if (state_dbg != 4'd5) break;
                if (mem_req === 1'b1 && memwrite === 1'b1) n++;
                @(negedge clk);
            end
            chk("sw_wait_cycles", 32'(n), 32'd15);
`ifdef EXCEPTION_EN
            chk("sw_timeout_state", 32'(state_dbg), 32'd15);
`else
            chk("sw_timeout_state", 32'(state_dbg), 32'd0);
`endif
            chk("sw_bus_err", 32'(bus_err), 32'd1);
            chk("sw_no_write_after", 32'(memwrite), 32'd0);
`ifdef EXCEPTION_EN
            @(negedge clk);
`endif
            op = OP_NOP; mem_ready = 1'b1;
            @(negedge clk);
            @(negedge clk);
            #1;
            chk("nop_back_to_fetch", 32'(state_dbg), 32'd0);
            chk("bus_err_sticky", 32'(bus_err), 32'd1);
        end

        // Reset during MEMRD discards the load.
        op = OP_LW; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 chk("lw_in_memrd", 32'(state_dbg), 32'd3);
        reset_n = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_memrd_state", 32'(state_dbg), 32'd0);
        chk("rst_memrd_regwrite", 32'(regwrite), 32'd0);
        chk("rst_clears_bus_err", 32'(bus_err), 32'd0);

        // mem_ready on the 15th (last) wait cycle still succeeds.
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 14; k++) @(negedge clk);
        #1 chk("late_ready_still_memrd", 32'(state_dbg), 32'd3);
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("late_ready_memwb", 32'(state_dbg), 32'd4);
        chk("late_ready_regwrite", 32'(regwrite), 32'd1);
        chk("late_ready_no_err", 32'(bus_err), 32'd0);

        // Unknown opcode.
        @(negedge clk);
        op = OP_BAD;
        @(negedge clk);
        @(negedge clk);
        #1;
`ifdef EXCEPTION_EN
        chk("bad_op_state", 32'(state_dbg), 32'd15);
        chk("bad_op_regwrite", 32'(regwrite), 32'd1);
`else
        chk("bad_op_state", 32'(state_dbg), 32'd0);
        chk("bad_op_regwrite", 32'(regwrite), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
